// File: rtl/sprite_scan_ctrl.sv
// sprite_scan_ctrl: scans a ROWS x COLS 1-bpp sprite out of a row ROM
// as a valid/ready pixel stream with frame and row markers.
module sprite_scan_ctrl #(
  parameter int ROWS = 48,
  parameter int COLS = 64,
  parameter int AW   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [AW-1:0]   rom_addr,
  input  logic [COLS-1:0] rom_data,
  output logic            pix_valid,
  input  logic            pix_ready,
  output logic            pix_data,
  output logic [AW-1:0]   pix_x,
  output logic [AW-1:0]   pix_y,
  output logic            sof,
  output logic            eol,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_e;

  localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   row_q, row_d;
  logic [AW-1:0]   col_q, col_d;
  logic [COLS-1:0] shreg_q, shreg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      shreg_q <= '1;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      shreg_q <= shreg_d;
    end
  end

  // Abort wins over acceptance; idle pixel line is refilled to background.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          shreg_d = '1;
        end else begin
          shreg_d = rom_data;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          shreg_d = '1;
        end else if (pix_ready) begin
          shreg_d = {shreg_q[COLS-2:0], 1'b1};
          if (col_q == LAST_COL) begin
            if (row_q != LAST_ROW) begin
              row_d   = row_q + AW'(1);
              col_d   = '0;
              state_d = FETCH;
            end else begin
              state_d = DONE;
            end
          end else begin
            col_d = col_q + AW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Row counter doubles as the registered ROM address.
  assign rom_addr  = row_q;
  assign pix_valid = (state_q == SHIFT);
  assign pix_data  = shreg_q[COLS-1];
  assign pix_x     = col_q;
  assign pix_y     = row_q;
  assign sof       = pix_valid && (row_q == '0) && (col_q == '0);
  assign eol       = pix_valid && (col_q == LAST_COL);
  assign busy      = (state_q == FETCH) || (state_q == SHIFT);
  assign done      = (state_q == DONE);

endmodule

// File: doc/sprite_scan_ctrl.md
SPRITE_SCAN_CTRL -- requirements
Module: sprite_scan_ctrl

Interface
REQ-001 Parameter ROWS, default 48, number of sprite rows scanned per frame.
REQ-002 Parameter COLS, default 64, pixels per row, equal to the ROM data width.
REQ-003 Parameter AW, default 6, width of the ROM address and of the pixel coordinates.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  frame request pulse, sampled only in IDLE.
REQ-008 abort  input  1  synchronous frame cancel.
REQ-009 rom_addr  output  AW  row address to the combinational sprite ROM.
REQ-010 rom_data  input  COLS  ROM row data; bit COLS-1 is the leftmost pixel.
REQ-011 pix_valid  output  1  pixel present on pix_data.
REQ-012 pix_ready  input  1  downstream accepts the pixel.
REQ-013 pix_data  output  1  pixel value (1 = background, 0 = sprite).
REQ-014 pix_x / pix_y  output  AW each  column / row of the current pixel.
REQ-015 sof / eol  output  1 each  first pixel of frame / last pixel of row, qualified by pix_valid.
REQ-016 busy  output  1  high in FETCH and SHIFT.
REQ-017 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, SHIFT and DONE.
REQ-019 IDLE -> FETCH on start=1 and abort=0; row and col SHALL clear to 0.
REQ-020 FETCH SHALL last exactly one cycle: latch rom_data[rom_addr] into a COLS-bit shift register, then go to SHIFT.
REQ-021 rom_addr SHALL be a register equal to the current row and SHALL stay stable throughout FETCH and SHIFT.
REQ-022 In SHIFT, pix_valid=1, pix_data=shreg[COLS-1], pix_x=col, pix_y=row.
REQ-023 A pixel is accepted when pix_valid and pix_ready are both 1 on the same edge; on acceptance shreg SHALL shift left by one and col SHALL increment.
REQ-024 While pix_valid=1 and pix_ready=0, pix_data, pix_x, pix_y, sof and eol SHALL hold unchanged.
REQ-025 When col=COLS-1 is accepted: if row<ROWS-1, increment row, clear col and go to FETCH; otherwise go to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then go to IDLE; done SHALL not be asserted on an aborted frame.
REQ-027 With pix_ready=1 continuously, each row SHALL take COLS+1 cycles; the first pix_valid SHALL occur 2 cycles after start is sampled; DONE SHALL be entered ROWS*(COLS+1) edges after start is sampled.
REQ-028 sof = pix_valid & (row==0) & (col==0); eol = pix_valid & (col==COLS-1).
REQ-029 start SHALL be ignored while busy=1 or in DONE.
REQ-030 abort=1 in FETCH or SHIFT SHALL return the FSM to IDLE on the next edge, with pix_valid=0 and no done pulse; abort has priority over acceptance and over start.
REQ-031 Counters SHALL never wrap: col stays ≤ COLS-1 and row stays ≤ ROWS-1.

Reset
REQ-032 rst_n=0 SHALL force, immediately and independently of clk: state=IDLE, row=0, col=0, shreg all ones, rom_addr=0, pix_valid=0, pix_data=1, pix_x=0, pix_y=0, sof=0, eol=0, busy=0, done=0.
REQ-033 Reset asserted mid-frame SHALL discard the frame; the first frame after release requires a new start.

Verification
REQ-034 Reset: assert rst_n=0 mid-SHIFT -> all outputs at the REQ-032 values within the same cycle, before the next clk edge.
REQ-035 Full frame, pix_ready=1: pulse start -> 3072 pixels; sof on (0,0); 48 eol pulses; row 2 pixel x=32 is 0; row 3 pixels x=32 and x=34 are 0 and x=33 is 1; done exactly 3120 edges after start is sampled.
REQ-036 Backpressure: pix_ready=0 for 5 cycles at (x=10, y=7) -> pix_data, pix_x and pix_y hold; no pixel is lost or duplicated; total frame length increases by exactly 5 cycles.
REQ-037 Abort at (x=20, y=30) -> next cycle pix_valid=0, busy=0, no done; a following start restarts at (0,0) with sof=1.
REQ-038 Start pulsed during SHIFT and during DONE -> ignored; exactly one done per frame; start and abort both high in IDLE -> remains in IDLE.
